// File: rtl/kb_pkg.sv
// Shared constants, decoder state encoding and byte-class helpers for the
// PS/2 Set-2 keyboard controller.
package kb_pkg;

  localparam int KB_EVT_W = 10;

  localparam logic [7:0] KB_PFX_EXT    = 8'hE0;
  localparam logic [7:0] KB_PFX_BRK    = 8'hF0;
  localparam logic [7:0] KB_PFX_E1     = 8'hE1;
  localparam logic [7:0] KB_ACK        = 8'hFA;
  localparam logic [7:0] KB_BAT_OK     = 8'hAA;
  localparam logic [7:0] KB_ECHO       = 8'hEE;
  localparam logic [7:0] KB_BAT_FAIL   = 8'hFC;
  localparam logic [7:0] KB_FAKE_SHIFT = 8'h12;
  localparam logic [7:0] KB_PAUSE_CODE = 8'h77;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } kb_state_e;

  function automatic logic kb_is_prefix(input logic [7:0] c);
    return (c == KB_PFX_EXT) || (c == KB_PFX_BRK) || (c == KB_PFX_E1);
  endfunction

  // Device replies and error bytes that never represent a key.
  function automatic logic kb_is_reply(input logic [7:0] c);
    return (c == KB_ACK) || (c == KB_BAT_OK) || (c == KB_ECHO) ||
           (c == KB_BAT_FAIL) || (c == 8'h00) || (c == 8'hFF);
  endfunction

endpackage

// File: rtl/kb_ctrl_if.sv
// Scan-receiver / CPU side signals of kb_ctrl; slave is the controller,
// master is whoever drives bytes in and pops events out.
interface kb_ctrl_if
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                code_valid_i;
  logic [7:0]          code_i;
  logic                evt_valid_o;
  logic [KB_EVT_W-1:0] evt_o;
  logic                pop_i;
  logic [CW-1:0]       count_o;
  logic                overflow_o;
  logic                clr_ovf_i;
  logic                irq_o;

  modport master (
    output code_valid_i, code_i, pop_i, clr_ovf_i,
    input  evt_valid_o, evt_o, count_o, overflow_o, irq_o
  );

  modport slave (
    input  code_valid_i, code_i, pop_i, clr_ovf_i,
    output evt_valid_o, evt_o, count_o, overflow_o, irq_o
  );
endinterface

// File: rtl/kb_evt_fifo.sv
// First-word-fall-through FIFO: a push is visible at dat_o the next cycle; a push
// while full is accepted only if the same cycle pops, otherwise the caller sees it refused.
module kb_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic [W-1:0]           dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic [W-1:0]  last_q;
  logic          do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = cnt_q;
  // Once drained, keep presenting the last consumed entry rather than stale RAM.
  assign dat_o   = empty_o ? last_q : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/kb_ctrl.sv
// PS/2 Set-2 sequence decoder feeding an event FIFO; event visible one cycle after its
// final byte. No backpressure to the receiver: events arriving while full are dropped and flagged.
module kb_ctrl
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int E1_SKIP    = 7
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  kb_ctrl_if.slave  kb
);
  localparam int SKW = $clog2(E1_SKIP + 1);

  kb_state_e           state_q, state_d;
  logic [SKW-1:0]      skip_q, skip_d;
  logic                ovf_q, ovf_d;
  logic                push;
  logic [KB_EVT_W-1:0] push_dat;
  logic                fifo_full, fifo_empty;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    push     = 1'b0;
    push_dat = {2'b00, kb.code_i};
    if (kb.code_valid_i) begin
      case (state_q)
        IDLE: begin
          if (kb.code_i == KB_PFX_EXT)      state_d = EXT;
          else if (kb.code_i == KB_PFX_BRK) state_d = BRK;
          else if (kb.code_i == KB_PFX_E1) begin
            state_d = SKIP;
            skip_d  = SKW'(E1_SKIP);
          end else if (!kb_is_reply(kb.code_i)) push = 1'b1;
        end
        EXT: begin
          if (kb.code_i == KB_PFX_BRK) state_d = EXT_BRK;
          else begin
            state_d  = IDLE;
            push     = !kb_is_prefix(kb.code_i) && (kb.code_i != KB_FAKE_SHIFT);
            push_dat = {2'b10, kb.code_i};
          end
        end
        BRK: begin
          state_d  = IDLE;
          push     = !kb_is_prefix(kb.code_i);
          push_dat = {2'b01, kb.code_i};
        end
        EXT_BRK: begin
          state_d  = IDLE;
          push     = !kb_is_prefix(kb.code_i) && (kb.code_i != KB_FAKE_SHIFT);
          push_dat = {2'b11, kb.code_i};
        end
        SKIP: begin
          // The Pause tail carries no usable key info; only its length matters.
          skip_d = skip_q - 1'b1;
          if (skip_q == SKW'(1)) begin
            state_d  = IDLE;
            push     = 1'b1;
            push_dat = {2'b10, KB_PAUSE_CODE};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so only an unpopped full FIFO drops.
  assign ovf_d = (push && fifo_full && !kb.pop_i) ? 1'b1 :
                 kb.clr_ovf_i                    ? 1'b0 : ovf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      skip_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      ovf_q   <= ovf_d;
    end
  end

  kb_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (KB_EVT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .dat_i   (push_dat),
    .pop_i   (kb.pop_i),
    .dat_o   (kb.evt_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (kb.count_o)
  );

  assign kb.evt_valid_o = ~fifo_empty;
  assign kb.overflow_o  = ovf_q;
  assign kb.irq_o       = ~fifo_empty | ovf_q;
endmodule
